// File: rtl/ps2_scancode_decoder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_bus_interface : memory-mapped register bus (master drives, slave answers)
// Rev 1.0
// ---------------------------------------------------------------------------
interface io_bus_interface;
  typedef logic [31:0] scalar_t;

  logic        read_en;
  logic        write_en;
  logic [31:0] address;
  logic [31:0] write_data;
  scalar_t     read_data;

  modport master (output read_en, write_en, address, write_data, input read_data);
  modport slave  (input read_en, write_en, address, write_data, output read_data);
endinterface
`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_scancode_decoder : set-2 scan bytes -> key events, FIFO + STATUS/DATA regs
// Rev 1.0
// ---------------------------------------------------------------------------
module ps2_scancode_decoder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0,
  parameter int          FIFO_DEPTH   = 8
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        byte_valid,
  input  wire logic [7:0]  byte_data,
  io_bus_interface.slave   io_bus,
  output logic             event_interrupt
);

  localparam int          PTR_W       = $clog2(FIFO_DEPTH);
  localparam int          CNT_W       = PTR_W + 1;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDRESS;
  localparam logic [31:0] DATA_ADDR   = BASE_ADDRESS + 32'd4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_PAUSE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic             enq;
  logic [9:0]       enq_evt;

  logic [9:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      read_data_q, read_data_d;

  logic             rd_status, rd_data, wr_status;
  logic             not_empty, full, deq, do_enq, ovf_set;
  logic             unused_wdata;

  function automatic logic is_response(input logic [7:0] b);
    return b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction

  // Prefix decoder: event word is {release, extended, code}
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    enq     = 1'b0;
    enq_evt = '0;
    if (byte_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (byte_data == 8'hE0)      state_d = S_EXT;
          else if (byte_data == 8'hF0) state_d = S_BRK;
          else if (byte_data == 8'hE1) begin
            state_d = S_PAUSE;
            skip_d  = 3'd7;
          end else if (!is_response(byte_data)) begin
            enq     = 1'b1;
            enq_evt = {2'b00, byte_data};
          end
        end
        S_EXT: begin
          if (byte_data == 8'hF0)           state_d = S_EXT_BRK;
          else if (byte_data == 8'hE0)      state_d = S_EXT;
          else if (is_response(byte_data))  state_d = S_IDLE;
          else begin
            enq     = 1'b1;
            enq_evt = {2'b01, byte_data};
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          if (byte_data == 8'hF0)           state_d = S_BRK;
          else if (byte_data == 8'hE0)      state_d = S_EXT;
          else if (is_response(byte_data))  state_d = S_IDLE;
          else begin
            enq     = 1'b1;
            enq_evt = {2'b10, byte_data};
            state_d = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
          if (byte_data != 8'hE0 && byte_data != 8'hF0 && !is_response(byte_data)) begin
            enq     = 1'b1;
            enq_evt = {2'b11, byte_data};
          end
        end
        S_PAUSE: begin
          // Remaining Pause bytes are swallowed unchecked
          if (skip_q <= 3'd1) begin
            enq     = 1'b1;
            enq_evt = {2'b01, 8'hE1};
            skip_d  = 3'd0;
            state_d = S_IDLE;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rd_status = io_bus.read_en  && (io_bus.address == STATUS_ADDR);
  assign rd_data   = io_bus.read_en  && (io_bus.address == DATA_ADDR);
  assign wr_status = io_bus.write_en && (io_bus.address == STATUS_ADDR);
  assign not_empty = (count_q != '0);
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign deq       = rd_data && not_empty;
  assign do_enq    = enq && (!full || deq);
  assign ovf_set   = enq && full && !deq;
  assign unused_wdata = ^io_bus.write_data;

  always_comb begin
    wr_ptr_d    = do_enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = deq    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q + CNT_W'(do_enq) - CNT_W'(deq);
    // A same-cycle overflow beats the clearing write
    overflow_d  = ovf_set ? 1'b1 : (wr_status ? 1'b0 : overflow_q);
    read_data_d = '0;
    if (rd_status)
      read_data_d = {30'd0, overflow_q, not_empty};
    else if (deq)
      read_data_d = {22'd0, fifo_mem_q[rd_ptr_q]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      skip_q      <= 3'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      read_data_q <= read_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) fifo_mem_q[wr_ptr_q] <= enq_evt;
  end

  assign io_bus.read_data = read_data_q;
  assign event_interrupt  = not_empty;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ps2_scancode_decoder : vector table, corner sequences, randomized model check
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ps2_scancode_decoder;
  localparam int          DEPTH  = 8;
  localparam logic [31:0] A_STAT = 32'h0;
  localparam logic [31:0] A_DATA = 32'h4;

  logic       clk = 1'b0;
  logic       reset;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       event_interrupt;

  io_bus_interface bus ();

  ps2_scancode_decoder #(.BASE_ADDRESS(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .io_bus          (bus),
    .event_interrupt (event_interrupt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] bytes;
    int          n;
    logic        has;
    logic [31:0] evt;
  } vec_t;

  vec_t vecs [16];

  // Reference model: prefix flags plus a queue standing in for the FIFO
  bit         m_ext, m_rel, m_ovf;
  int         m_pause;
  logic [9:0] m_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] b, input logic rd, input logic wr,
                       input logic [31:0] addr, output logic [31:0] rdata);
    byte_valid      = v;
    byte_data       = b;
    bus.read_en     = rd;
    bus.write_en    = wr;
    bus.address     = addr;
    bus.write_data  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    rdata           = bus.read_data;
    byte_valid      = 1'b0;
    bus.read_en     = 1'b0;
    bus.write_en    = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    logic [31:0] d;
    cycle(1'b1, b, 1'b0, 1'b0, 32'h0, d);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] d);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, addr, d);
  endtask

  task automatic wr(input logic [31:0] addr);
    logic [31:0] d;
    cycle(1'b0, 8'h00, 1'b0, 1'b1, addr, d);
  endtask

  task automatic do_reset();
    logic [31:0] d;
    reset = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, d);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, d);
    reset = 1'b0;
    m_ext = 0; m_rel = 0; m_ovf = 0; m_pause = 0;
    m_q.delete();
  endtask

  task automatic model_decode(input logic [7:0] b, output bit has, output logic [9:0] evt);
    has = 0;
    evt = '0;
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) begin has = 1; evt = {2'b01, 8'hE1}; end
    end else if (b == 8'hE0) begin
      if (m_ext && m_rel) begin m_ext = 0; m_rel = 0; end
      else begin m_ext = 1; m_rel = 0; end
    end else if (b == 8'hF0) begin
      if (m_ext && m_rel) begin m_ext = 0; m_rel = 0; end
      else m_rel = 1;
    end else if (b == 8'hE1 && !m_ext && !m_rel) begin
      m_pause = 7;
    end else if (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
      m_ext = 0; m_rel = 0;
    end else begin
      has = 1;
      evt = {m_rel, m_ext, b};
      m_ext = 0; m_rel = 0;
    end
  endtask

  function automatic logic [7:0] pick_byte();
    logic [7:0] resp [6] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    case ($urandom_range(0, 7))
      0: return 8'hE0;
      1: return 8'hF0;
      2: return 8'hE1;
      3: return resp[$urandom_range(0, 5)];
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic [31:0] d, exp_rd, addr;
    logic [7:0]  b;
    logic [9:0]  evt;
    bit          v, rdo, wro, has, deq;
    int          op, pre;

    reset = 1'b1; byte_valid = 0; byte_data = 0;
    bus.read_en = 0; bus.write_en = 0; bus.address = 0; bus.write_data = 0;

    vecs[0]  = '{64'h1C,               1, 1'b1, 32'h01C};
    vecs[1]  = '{64'hF01C,             2, 1'b1, 32'h21C};
    vecs[2]  = '{64'hE0F074,           3, 1'b1, 32'h374};
    vecs[3]  = '{64'hE074,             2, 1'b1, 32'h174};
    vecs[4]  = '{64'hE11477E1F014F077, 8, 1'b1, 32'h1E1};
    vecs[5]  = '{64'h1C,               1, 1'b1, 32'h01C};
    vecs[6]  = '{64'hFAAAF0FA,         4, 1'b0, 32'h000};
    vecs[7]  = '{64'h1C,               1, 1'b1, 32'h01C};
    vecs[8]  = '{64'hE0E012,           3, 1'b1, 32'h112};
    vecs[9]  = '{64'hF0F012,           3, 1'b1, 32'h212};
    vecs[10] = '{64'hF0E070,           3, 1'b1, 32'h170};
    vecs[11] = '{64'hE0F0E0,           3, 1'b0, 32'h000};
    vecs[12] = '{64'hE0FE,             2, 1'b0, 32'h000};
    vecs[13] = '{64'hE0F0F01C,         4, 1'b1, 32'h01C};
    vecs[14] = '{64'hE0E1,             2, 1'b1, 32'h1E1};
    vecs[15] = '{64'hF000,             2, 1'b0, 32'h000};

    // Reset state, sampled while reset is still held
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, d);
    check("reset_rdata", d, 32'h0);
    check("reset_irq", {31'd0, event_interrupt}, 32'h0);
    do_reset();
    rd(A_STAT, d);
    check("reset_status", d, 32'h0);

    foreach (vecs[i]) begin
      for (int j = 0; j < vecs[i].n; j++) send(vecs[i].bytes[8*(vecs[i].n-1-j) +: 8]);
      check($sformatf("v%0d_irq", i), {31'd0, event_interrupt}, {31'd0, vecs[i].has});
      rd(A_STAT, d);
      check($sformatf("v%0d_status_pre", i), d, {31'd0, vecs[i].has});
      rd(A_DATA, d);
      check($sformatf("v%0d_data", i), d, vecs[i].evt);
      rd(A_STAT, d);
      check($sformatf("v%0d_status_post", i), d, 32'h0);
    end

    // Overflow: nine make codes into an eight-deep FIFO
    do_reset();
    for (int k = 1; k <= DEPTH + 1; k++) send(8'(k));
    rd(A_STAT, d);
    check("ovf_status", d, 32'h3);
    for (int k = 1; k <= DEPTH + 1; k++) begin
      rd(A_DATA, d);
      check($sformatf("ovf_data%0d", k), d, (k <= DEPTH) ? 32'(k) : 32'h0);
    end
    wr(A_STAT);
    rd(A_STAT, d);
    check("ovf_cleared", d, 32'h0);

    // Full FIFO with enqueue and dequeue on the same cycle
    for (int k = 1; k <= DEPTH; k++) send(8'(k));
    cycle(1'b1, 8'h09, 1'b1, 1'b0, A_DATA, d);
    check("full_swap_data", d, 32'h1);
    rd(A_STAT, d);
    check("full_swap_status", d, 32'h1);
    for (int k = 2; k <= DEPTH + 1; k++) begin
      rd(A_DATA, d);
      check($sformatf("full_swap_drain%0d", k), d, 32'(k));
    end

    // Reset in the middle of a break-extended prefix
    send(8'hE0);
    send(8'hF0);
    do_reset();
    rd(A_STAT, d);
    check("midreset_status", d, 32'h0);
    send(8'h1C);
    rd(A_DATA, d);
    check("midreset_data", d, 32'h1C);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      v   = ($urandom_range(0, 2) != 0);
      b   = pick_byte();
      op  = $urandom_range(0, 9);
      rdo = 0; wro = 0; addr = 32'h0;
      case (op)
        0, 1, 2: begin rdo = 1; addr = A_DATA; end
        3:       begin rdo = 1; addr = A_STAT; end
        4:       begin wro = 1; addr = A_STAT; end
        5:       begin wro = 1; addr = A_DATA; end
        6:       begin rdo = 1; addr = 32'h8; end
        default: ;
      endcase
      pre    = m_q.size();
      exp_rd = 32'h0;
      if (rdo && addr == A_DATA && pre > 0) exp_rd = {22'd0, m_q[0]};
      if (rdo && addr == A_STAT)            exp_rd = {30'd0, m_ovf, pre != 0};
      deq = rdo && addr == A_DATA && pre > 0;
      has = 0;
      if (v) model_decode(b, has, evt);
      if (deq) void'(m_q.pop_front());
      if (wro && addr == A_STAT) m_ovf = 0;
      if (has) begin
        if (pre < DEPTH || deq) m_q.push_back(evt);
        else m_ovf = 1;
      end
      cycle(v, b, rdo, wro, addr, d);
      if (rdo) check("rand_rdata", d, exp_rd);
      check("rand_irq", {31'd0, event_interrupt}, {31'd0, m_q.size() != 0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Converts the raw scan-code set 2 byte stream from the PS/2 receive path into complete key events. It strips the 0xE0 (extended) and 0xF0 (break) prefixes, collapses the 8-byte Pause sequence into one event, and discards device response bytes. Events are buffered in a FIFO and exposed as two memory-mapped registers on the I/O bus, with an interrupt while events are pending. It sits directly downstream of the PS/2 byte receiver, ahead of software.

## Interface
- BASE_ADDRESS, 0: byte address of STATUS; DATA is at BASE_ADDRESS + 4.
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥ 2.

- clk  in  1  system clock; the block uses only this clock.
- reset  in  1  synchronous, active-high reset.
- byte_valid  in  1  one-cycle strobe: byte_data holds a newly received byte.
- byte_data  in  8  received scan-code byte.
- io_bus  io_bus_interface.slave  -  read_en, write_en, address, write_data in; read_data (32-bit scalar_t) out.
- event_interrupt  out  1  high while the FIFO is non-empty.

## Operation
- Event word layout:
  - bits 7:0: code.
  - bit 8: extended.
  - bit 9: release.
  - bits 31:10: zero.
- Decoder FSM, updated only on cycles with byte_valid. Transitions by byte:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> PAUSE, with skip counter = 7.
    - FA, AA, EE, FE, 00 or FF -> discarded; stay in IDLE.
    - Any other byte -> enqueue {rel=0, ext=0, code=byte}; stay in IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay in EXT.
    - Response byte -> IDLE.
    - Other -> enqueue {0, 1, byte}; go to IDLE.
  - BRK:
    - F0 -> stay in BRK.
    - E0 -> EXT (resynchronise).
    - Response byte -> IDLE.
    - Other -> enqueue {1, 0, byte}; go to IDLE.
  - EXT_BRK:
    - E0 or F0 -> IDLE, no event.
    - Response byte -> IDLE.
    - Other -> enqueue {1, 1, byte}; go to IDLE.
  - PAUSE:
    - Each byte decrements the skip counter; contents are not checked.
    - When the counter reaches 0 -> enqueue {0, 1, 0xE1}; go to IDLE.
- STATUS register (read):
  - bit 0: FIFO non-empty.
  - bit 1: sticky overflow.
  - Other bits: 0.
- STATUS register (write): a write of any value clears overflow.
- DATA register (read): returns the head event and dequeues it. If the FIFO is empty, returns 0 and does not dequeue.
- FIFO full at enqueue, with no same-cycle dequeue: the new event is dropped and overflow is set. Older events are preserved.
- Enqueue and dequeue in the same cycle with the FIFO full: both take effect, and overflow is not set.
- Reads of other addresses: read_data = 0, no side effects. Writes to DATA are ignored.
- Reset:
  - FSM -> IDLE; skip counter = 0.
  - FIFO empty; overflow = 0.
  - read_data = 0; event_interrupt = 0.
  - Reset mid-sequence discards any partial prefix state.

## Timing
- One byte can be accepted per cycle; byte_valid may be asserted on consecutive cycles.
- The completing byte on cycle N:
  - The event is written to the FIFO at the clk edge ending cycle N.
  - STATUS bit 0 and event_interrupt go high in cycle N+1.
- Reads: read_data is registered.
  - A read_en presented on cycle N drives valid read_data during cycle N+1.
  - The dequeue, if any, takes effect at the end of cycle N.
- Back-to-back DATA reads return successive events.
- STATUS reflects the FIFO state sampled on the read cycle.
- An overflow set and a STATUS write in the same cycle: set wins.
- FIFO occupancy counter width is clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.

## Test plan
- Byte 1C -> one event 0x0000001C.
- Bytes F0 1C -> event 0x0000021C. STATUS = 1 before the read and 0 after it.
- Bytes E0 F0 74 -> event 0x00000374. Bytes E0 74 -> event 0x00000174.
- Pause sequence E1 14 77 E1 F0 14 F0 77, sent on consecutive cycles -> exactly one event 0x000001E1. A following byte 1C -> 0x0000001C.
- Bytes FA and AA in IDLE, and F0 FA -> no events and interrupt stays low. A following 1C -> 0x0000001C, not a release.
- Send FIFO_DEPTH+1 make codes 01..09 with no reads:
  - STATUS = 3.
  - DATA reads return 01..08; the 9th read returns 0.
  - A write to STATUS then gives STATUS = 0.
  - Also verify a same-cycle full enqueue with dequeue sets no overflow.
- Assert reset after E0 F0 -> STATUS = 0. A following byte 1C -> 0x0000001C.
